mic_spi_capture: RTL
====================

// Module: mic_spi_capture
// PURPOSE
//  SPI master for the 12-bit microphone ADC (ADCS7476-style frame: 4 leading zeros + 12 data bits, MSB first).
//  Runs conversions at a fixed sample rate and delivers each 12-bit result with a 1-cycle valid strobe.
//  Sits directly upstream of the volume/peak detector and the audio processing chain.
//  Its cs_n output is the conversion framing signal those stages key on.
// PARAMETERS
//  SCLK_DIV    50    clk cycles per SCLK half-period (100 MHz / 100 = 1 MHz SCLK); must be >= 4
//  SAMPLE_DIV  5000  clk cycles between conversion starts (20 kHz); must be >= 32*SCLK_DIV + 2
// PORTS
//  clk          in   1   system clock, 100 MHz
//  reset        in   1   asynchronous, active-high reset
//  miso         in   1   ADC serial data out (asynchronous to clk)
//  sclk         out  1   SPI clock to ADC; idles high
//  cs_n         out  1   ADC chip select, active low; low only during a frame
//  sample       out  12  last completed conversion result, unsigned
//  sample_valid out  1   1-cycle pulse when sample updates
//  frame_err    out  1   leading 4 bits of last frame were not all zero; held until next frame completes
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - cs_n=1, sclk=1, sample=0, sample_valid=0, frame_err=0.
//  - FSM to IDLE; all counters 0.
//  miso path:
//  - Passes through a 2-flop synchroniser before use (2-cycle latency; absorbed by SCLK_DIV >= 4).
//  Sample timer:
//  - Free-running 0..SAMPLE_DIV-1; wraps to 0.
//  - Width = $clog2(SAMPLE_DIV).
//  FSM states:
//  - IDLE: cs_n=1, sclk=1. When timer==0, go to SHIFT. Cs_n drives low on that edge (cycle T0).
//  - SHIFT: a half-period counter toggles sclk every SCLK_DIV cycles.
//    - First sclk fall is at T0+SCLK_DIV.
//    - Rising edges fall at T0+2k*SCLK_DIV, for k=1..16.
//    - On the clk edge that drives sclk 0->1, the synchronised miso is shifted into a 16-bit register (shift left, LSB in).
//    - A 5-bit bit counter counts rises. After the 16th rise, go to DONE.
//  - DONE (exactly one cycle, at T0+32*SCLK_DIV+1):
//    - cs_n<=1, sclk stays 1.
//    - sample<=shift[11:0], sample_valid<=1.
//    - frame_err<=|shift[15:12].
//    - Next state IDLE.
//  Frame timing:
//  - Exactly 16 sclk falling and 16 rising edges per frame. Sclk never toggles while cs_n=1.
//  - sample_valid is high for exactly one clk cycle per frame; otherwise 0.
//  - Latency: cs_n fall to sample_valid = 32*SCLK_DIV+1 cycles.
//  Timer and frame interaction:
//  - The timer keeps running during a frame.
//  - The next frame starts on the next timer==0 while in IDLE.
//  - Start period is exactly SAMPLE_DIV cycles.
//  Reset during a frame:
//  - Frame is abandoned immediately: cs_n=1, sclk=1.
//  - No sample_valid pulse; sample and frame_err are cleared.
//  - First frame starts on the first clk edge after reset release (timer==0 in IDLE).
//  Downstream use:
//  - Consumers must qualify sample with sample_valid.
//  - sample is stable from sample_valid until the next sample_valid.
// TESTING (sim params SCLK_DIV=2, SAMPLE_DIV=100; bench ADC model drives miso on sclk fall)
//  1. reset=1 -> cs_n=1, sclk=1, sample=0, sample_valid=0, frame_err=0; after release, cs_n falls on the 1st edge.
//  2. ADC word 16'h0ABC -> sample=12'hABC, one sample_valid pulse 65 cycles after cs_n fall, frame_err=0.
//  3. Words 16'h0000 then 16'h0FFF -> cs_n falls are exactly 100 cycles apart; samples are 0x000 then 0xFFF.
//  4. Word 16'h8123 then 16'h0123 -> sample 0x123 both times; frame_err 1 after frame 1, 0 after frame 2.
//  5. reset pulsed 20 cycles into a frame -> cs_n/sclk go high the same cycle, no sample_valid; next frame completes correctly.
//  6. Monitor over 10 frames -> 16 sclk falls per cs_n-low window, none while cs_n high, sample_valid count = 10.

Source files
------------

// File: rtl/mic_spi_capture.sv
// SPI master for an ADCS7476-style 12-bit ADC.
// It starts a 16-clock frame every SAMPLE_DIV cycles and strobes out each 12-bit result.
module mic_spi_capture #(
  parameter int unsigned SCLK_DIV   = 50,
  parameter int unsigned SAMPLE_DIV = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        miso,
  output logic        sclk,
  output logic        cs_n,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(SAMPLE_DIV);
  localparam int unsigned HW = $clog2(SCLK_DIV);
  localparam int unsigned BW = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [15:0]     shift_q, shift_d;
  logic            sync1_q, sync2_q;
  logic            sclk_q, sclk_d;
  logic            cs_n_q, cs_n_d;
  logic [11:0]     sample_q, sample_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            half_tick;
  logic            timer_zero;

  assign half_tick  = (hcnt_q == HW'(SCLK_DIV - 1));
  assign timer_zero = (timer_q == '0);
  assign timer_d    = (timer_q == TW'(SAMPLE_DIV - 1)) ? '0 : timer_q + TW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (timer_zero) state_d = SHIFT;
      // The 16th sclk rise ends the shifting phase
      SHIFT:   if (half_tick && !sclk_q && (bcnt_q == BW'(15))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hcnt_d   = hcnt_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (timer_zero) begin
          cs_n_d = 1'b0;
          sclk_d = 1'b1;
          hcnt_d = '0;
          bcnt_d = '0;
        end
      end
      SHIFT: begin
        hcnt_d = half_tick ? '0 : hcnt_q + HW'(1);
        if (half_tick) begin
          sclk_d = ~sclk_q;
          // Capture on the edge that drives sclk high
          if (!sclk_q) begin
            bcnt_d  = bcnt_q + BW'(1);
            shift_d = {shift_q[14:0], sync2_q};
          end
        end
      end
      DONE: begin
        cs_n_d   = 1'b1;
        sclk_d   = 1'b1;
        sample_d = shift_q[11:0];
        valid_d  = 1'b1;
        err_d    = |shift_q[15:12];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q  <= '0;
      hcnt_q   <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sclk_q   <= 1'b1;
      cs_n_q   <= 1'b1;
      sample_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      hcnt_q   <= hcnt_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      sync1_q  <= miso;
      sync2_q  <= sync1_q;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign sclk         = sclk_q;
  assign cs_n         = cs_n_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;

endmodule
